// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single memory port between instruction fetch and
// the load/store unit. Only one transaction is outstanding at a time. The
// winning request is held on the port until it is granted, and the response is
// routed back to the requester that owns it. A streak counter stops a stream
// of LSU requests from starving fetch.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    // instruction fetch side
    input  logic            ifu_req_i,
    input  logic [XLEN-1:0] ifu_adr_i,
    input  logic            ifu_flush_i,
    output logic            ifu_gnt_o,
    output logic            ifu_rvalid_o,
    output logic [XLEN-1:0] ifu_rdata_o,
    // load/store side
    input  logic            lsu_req_i,
    input  logic [XLEN-1:0] lsu_adr_i,
    input  logic            lsu_we_i,
    input  logic [2:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    // memory port
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic [SW-1:0]  streak_q, streak_d;
    logic           drop_q, drop_d;

    logic           req;        // request on the memory port this cycle
    logic           sel_lsu;    // requester currently driving the port
    logic [3:0]     be_base;
    logic [3:0]     lsu_be;
    logic [XLEN-1:0] lsu_wdata_aligned;
    logic           rsp_valid;

    // Bit 2 of the size only carries sign information for the LSU.
    logic           unused_size_bit;
    assign unused_size_bit = lsu_size_i[2];

    // Pick the requester that drives the port: arbitrate in IDLE, else keep the latched owner.
    always_comb begin
        req     = 1'b0;
        sel_lsu = OWN_IFU;
        case (state_q)
            IDLE: begin
                req     = ifu_req_i | lsu_req_i;
                sel_lsu = lsu_req_i & ~((streak_q == STREAK_MAX) & ifu_req_i);
            end
            ISSUE: begin
                req     = 1'b1;
                sel_lsu = owner_q;
            end
            default: begin
                req     = 1'b0;
                sel_lsu = owner_q;
            end
        endcase
    end

    // Byte-enable pattern from the access size, before lane alignment.
    always_comb begin
        be_base = 4'b1111;
        case (lsu_size_i[1:0])
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    // Enables and data that straddle the word boundary are simply cut off;
    // misaligned accesses trap in execute before they reach this block.
    assign lsu_be            = be_base << lsu_adr_i[1:0];
    assign lsu_wdata_aligned = lsu_wdata_i << {lsu_adr_i[1:0], 3'b000};

    assign mem_req_o   = req;
    assign mem_adr_o   = !req ? '0 : (sel_lsu ? lsu_adr_i : ifu_adr_i);
    assign mem_we_o    = req & sel_lsu & lsu_we_i;
    assign mem_be_o    = !req ? 4'b0000 : (sel_lsu ? lsu_be : 4'b1111);
    assign mem_wdata_o = (req & sel_lsu) ? lsu_wdata_aligned : '0;

    assign ifu_gnt_o = req & mem_gnt_i & ~sel_lsu;
    assign lsu_gnt_o = req & mem_gnt_i & sel_lsu;

    // A response outside WAIT is a protocol error and is ignored.
    assign rsp_valid    = (state_q == WAIT) & mem_rvalid_i;
    assign ifu_rvalid_o = rsp_valid & (owner_q == OWN_IFU) & ~drop_q & ~ifu_flush_i;
    assign lsu_rvalid_o = rsp_valid & (owner_q == OWN_LSU);
    assign ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
    assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;

    assign busy_o = (state_q != IDLE);

    // Next state, owner, flush-drop flag and LSU streak counter.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        drop_d   = drop_q;
        streak_d = streak_q;

        case (state_q)
            IDLE: begin
                drop_d = ifu_gnt_o & ifu_flush_i;
                if (req) begin
                    owner_d = sel_lsu;
                    state_d = mem_gnt_i ? WAIT : ISSUE;
                end
            end
            ISSUE: begin
                if ((owner_q == OWN_IFU) && ifu_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if ((owner_q == OWN_IFU) && ifu_flush_i) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
        endcase

        // LSU grants only count against fetch while fetch is actually waiting.
        if (lsu_gnt_o && ifu_req_i && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
        end
        if (ifu_gnt_o) begin
            streak_d = '0;
        end
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IFU;
            streak_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Expected responses are queued when
// the request is granted and are compared when the DUT pulses an rvalid.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            ifu_req_i, ifu_flush_i;
    logic [XLEN-1:0] ifu_adr_i;
    logic            ifu_gnt_o, ifu_rvalid_o;
    logic [XLEN-1:0] ifu_rdata_o;
    logic            lsu_req_i, lsu_we_i;
    logic [XLEN-1:0] lsu_adr_i, lsu_wdata_i;
    logic [2:0]      lsu_size_i;
    logic            lsu_gnt_o, lsu_rvalid_o;
    logic [XLEN-1:0] lsu_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [XLEN-1:0] mem_adr_o, mem_wdata_o;
    logic [3:0]      mem_be_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(XLEN), .MAX_LSU_STREAK(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ifu_req_i    (ifu_req_i),
        .ifu_adr_i    (ifu_adr_i),
        .ifu_flush_i  (ifu_flush_i),
        .ifu_gnt_o    (ifu_gnt_o),
        .ifu_rvalid_o (ifu_rvalid_o),
        .ifu_rdata_o  (ifu_rdata_o),
        .lsu_req_i    (lsu_req_i),
        .lsu_adr_i    (lsu_adr_i),
        .lsu_we_i     (lsu_we_i),
        .lsu_size_i   (lsu_size_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_gnt_o    (lsu_gnt_o),
        .lsu_rvalid_o (lsu_rvalid_o),
        .lsu_rdata_o  (lsu_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_adr_o    (mem_adr_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic            lsu;
        logic [XLEN-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_mem_req"}, mem_req_o, 1'b0);
        chk({tag, "_mem_adr"}, mem_adr_o, 32'h0);
        chk1({tag, "_mem_we"}, mem_we_o, 1'b0);
        chk({tag, "_mem_be"}, {28'b0, mem_be_o}, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk1({tag, "_ifu_gnt"}, ifu_gnt_o, 1'b0);
        chk1({tag, "_lsu_gnt"}, lsu_gnt_o, 1'b0);
        chk1({tag, "_ifu_rvalid"}, ifu_rvalid_o, 1'b0);
        chk1({tag, "_lsu_rvalid"}, lsu_rvalid_o, 1'b0);
        chk({tag, "_ifu_rdata"}, ifu_rdata_o, 32'h0);
        chk({tag, "_lsu_rdata"}, lsu_rdata_o, 32'h0);
        chk1({tag, "_busy"}, busy_o, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // LSU store granted at once, answered the following cycle.
    task automatic store(input logic [31:0] adr, input logic [2:0] size, input logic [31:0] wdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b1;
        lsu_adr_i   = adr;
        lsu_size_i  = size;
        lsu_wdata_i = wdata;
        mem_gnt_i   = 1'b1;
        @(negedge clk);
        chk1("st_gnt", lsu_gnt_o, 1'b1);
        chk1("st_we", mem_we_o, 1'b1);
        chk("st_adr", mem_adr_o, adr);
        chk("st_be", {28'b0, mem_be_o}, {28'b0, exp_be});
        chk("st_wdata", mem_wdata_o, exp_wdata);
        $display("store adr=%h size=%0d be=%b wdata=%h", adr, size, mem_be_o, mem_wdata_o);
        sb.push_back('{1'b1, 32'h0});
        step();
        lsu_req_i    = 1'b0;
        lsu_we_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0;
        step();
        mem_rvalid_i = 1'b0;
    endtask

    // Response monitor: every rvalid pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (reset_n && (ifu_rvalid_o || lsu_rvalid_o)) begin
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL rsp_unexpected observed ifu=%0b lsu=%0b expected no pulse",
                       ifu_rvalid_o, lsu_rvalid_o);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk1("rsp_ifu_pulse", ifu_rvalid_o, ~mon_e.lsu);
                chk1("rsp_lsu_pulse", lsu_rvalid_o, mon_e.lsu);
                chk("rsp_data", mon_e.lsu ? lsu_rdata_o : ifu_rdata_o, mon_e.data);
                $display("response owner=%s data=%h", mon_e.lsu ? "LSU" : "IFU",
                         mon_e.lsu ? lsu_rdata_o : ifu_rdata_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=still running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        ifu_req_i    = 1'b0;
        ifu_adr_i    = '0;
        ifu_flush_i  = 1'b0;
        lsu_req_i    = 1'b0;
        lsu_adr_i    = '0;
        lsu_we_i     = 1'b0;
        lsu_size_i   = 3'b010;
        lsu_wdata_i  = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        step();
        step();
        @(negedge clk);
        chk_quiet("reset");
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk_quiet("idle");
        step();

        // IFU alone: grant same cycle, response two cycles later
        ifu_req_i = 1'b1;
        ifu_adr_i = 32'h100;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t1_ifu_gnt", ifu_gnt_o, 1'b1);
        chk1("t1_lsu_gnt", lsu_gnt_o, 1'b0);
        chk1("t1_mem_req", mem_req_o, 1'b1);
        chk("t1_adr", mem_adr_o, 32'h100);
        chk("t1_be", {28'b0, mem_be_o}, 32'hF);
        chk1("t1_we", mem_we_o, 1'b0);
        chk1("t1_busy_t0", busy_o, 1'b0);
        $display("fetch adr=%h granted", mem_adr_o);
        sb.push_back('{1'b0, 32'hDEADBEEF});
        step();
        ifu_req_i = 1'b0;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk1("t1_busy_t1", busy_o, 1'b1);
        chk1("t1_req_wait", mem_req_o, 1'b0);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        @(negedge clk);
        chk1("t1_busy_t2", busy_o, 1'b1);
        chk1("t1_rvalid", ifu_rvalid_o, 1'b1);
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk1("t1_busy_t3", busy_o, 1'b0);
        chk1("t1_rvalid_off", ifu_rvalid_o, 1'b0);
        step();

        // both request, memory stalls three cycles: LSU owns, IFU next
        ifu_req_i  = 1'b1;
        ifu_adr_i  = 32'h200;
        lsu_req_i  = 1'b1;
        lsu_adr_i  = 32'h344;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        mem_gnt_i  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t2_adr_hold", mem_adr_o, 32'h344);
            chk1("t2_req_hold", mem_req_o, 1'b1);
            chk1("t2_no_lsu_gnt", lsu_gnt_o, 1'b0);
            chk1("t2_no_ifu_gnt", ifu_gnt_o, 1'b0);
            step();
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t2_lsu_gnt", lsu_gnt_o, 1'b1);
        chk1("t2_ifu_gnt", ifu_gnt_o, 1'b0);
        chk("t2_adr", mem_adr_o, 32'h344);
        chk("t2_be", {28'b0, mem_be_o}, 32'hF);
        $display("load adr=%h granted after stall", mem_adr_o);
        sb.push_back('{1'b1, 32'h11112222});
        step();
        lsu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h11112222;
        @(negedge clk);
        chk1("t2_wait_req", mem_req_o, 1'b0);
        chk1("t2_wait_ifu_gnt", ifu_gnt_o, 1'b0);
        step();
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        @(negedge clk);
        chk1("t2_ifu_next", ifu_gnt_o, 1'b1);
        chk("t2_ifu_adr", mem_adr_o, 32'h200);
        $display("fetch adr=%h granted", mem_adr_o);
        sb.push_back('{1'b0, 32'h33334444});
        step();
        ifu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h33334444;
        step();
        mem_rvalid_i = 1'b0;

        // stores: byte enables and lane alignment
        store(32'h203, 3'b001, 32'h0000ABCD, 4'b1000, 32'hCD000000);
        store(32'h202, 3'b001, 32'h0000ABCD, 4'b1100, 32'hABCD0000);
        store(32'h001, 3'b000, 32'h0000005A, 4'b0010, 32'h00005A00);
        store(32'h300, 3'b010, 32'h12345678, 4'b1111, 32'h12345678);
        store(32'h202, 3'b101, 32'h0000BEEF, 4'b1100, 32'hBEEF0000);

        // LSU streak: four LSU grants, then IFU forced, then LSU again
        ifu_adr_i  = 32'h400;
        lsu_adr_i  = 32'h500;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'b010;
        for (int i = 0; i < 6; i++) begin
            logic exp_lsu;
            exp_lsu   = (i != 4);
            ifu_req_i = 1'b1;
            lsu_req_i = 1'b1;
            mem_gnt_i = 1'b1;
            @(negedge clk);
            chk1("t4_lsu_gnt", lsu_gnt_o, exp_lsu);
            chk1("t4_ifu_gnt", ifu_gnt_o, ~exp_lsu);
            chk("t4_adr", mem_adr_o, exp_lsu ? 32'h500 : 32'h400);
            $display("streak step %0d winner=%s", i, lsu_gnt_o ? "LSU" : "IFU");
            sb.push_back('{exp_lsu, 32'hA0 + 32'(i)});
            step();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hA0 + 32'(i);
            @(negedge clk);
            chk1("t4_wait_no_gnt", ifu_gnt_o, 1'b0);
            step();
            mem_rvalid_i = 1'b0;
        end
        ifu_req_i = 1'b0;
        lsu_req_i = 1'b0;

        // flush during WAIT drops the fetch response
        ifu_req_i = 1'b1;
        ifu_adr_i = 32'h600;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t5a_gnt", ifu_gnt_o, 1'b1);
        step();
        ifu_req_i   = 1'b0;
        mem_gnt_i   = 1'b0;
        ifu_flush_i = 1'b1;
        step();
        ifu_flush_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        @(negedge clk);
        chk1("t5a_dropped", ifu_rvalid_o, 1'b0);
        chk1("t5a_busy", busy_o, 1'b1);
        $display("fetch adr=600 flushed, response dropped");
        step();
        mem_rvalid_i = 1'b0;

        // following fetch returns normally
        ifu_req_i = 1'b1;
        ifu_adr_i = 32'h604;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t5b_gnt", ifu_gnt_o, 1'b1);
        sb.push_back('{1'b0, 32'h600D0001});
        step();
        ifu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h600D0001;
        step();
        mem_rvalid_i = 1'b0;

        // flush coincident with the response
        ifu_req_i = 1'b1;
        ifu_adr_i = 32'h608;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t5c_gnt", ifu_gnt_o, 1'b1);
        step();
        ifu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        ifu_flush_i  = 1'b1;
        mem_rdata_i  = 32'hBAD1BAD1;
        @(negedge clk);
        chk1("t5c_dropped", ifu_rvalid_o, 1'b0);
        $display("fetch adr=608 flushed with response, dropped");
        step();
        mem_rvalid_i = 1'b0;
        ifu_flush_i  = 1'b0;

        // flush in the grant cycle: request still granted, response dropped
        ifu_req_i   = 1'b1;
        ifu_adr_i   = 32'h60C;
        mem_gnt_i   = 1'b1;
        ifu_flush_i = 1'b1;
        @(negedge clk);
        chk1("t5d_gnt", ifu_gnt_o, 1'b1);
        step();
        ifu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        ifu_flush_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD2BAD2;
        @(negedge clk);
        chk1("t5d_dropped", ifu_rvalid_o, 1'b0);
        $display("fetch adr=60c flushed at grant, dropped");
        step();
        mem_rvalid_i = 1'b0;

        // flush in ISSUE keeps the request on the port, response dropped
        ifu_req_i = 1'b1;
        ifu_adr_i = 32'h610;
        mem_gnt_i = 1'b0;
        step();
        ifu_flush_i = 1'b1;
        @(negedge clk);
        chk1("t5e_req_kept", mem_req_o, 1'b1);
        chk("t5e_adr", mem_adr_o, 32'h610);
        step();
        ifu_flush_i = 1'b0;
        mem_gnt_i   = 1'b1;
        @(negedge clk);
        chk1("t5e_gnt", ifu_gnt_o, 1'b1);
        step();
        ifu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD3BAD3;
        @(negedge clk);
        chk1("t5e_dropped", ifu_rvalid_o, 1'b0);
        $display("fetch adr=610 flushed in issue, dropped");
        step();
        mem_rvalid_i = 1'b0;

        // flush does not affect an LSU response
        lsu_req_i = 1'b1;
        lsu_adr_i = 32'h700;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t5f_gnt", lsu_gnt_o, 1'b1);
        sb.push_back('{1'b1, 32'h77770000});
        step();
        lsu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        ifu_flush_i  = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77770000;
        step();
        ifu_flush_i  = 1'b0;
        mem_rvalid_i = 1'b0;

        // stray response in IDLE is ignored
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555AAAA;
        @(negedge clk);
        chk1("stray_ifu", ifu_rvalid_o, 1'b0);
        chk1("stray_lsu", lsu_rvalid_o, 1'b0);
        chk1("stray_busy", busy_o, 1'b0);
        step();
        mem_rvalid_i = 1'b0;

        // reset while waiting: outputs clear at once, then normal service
        ifu_req_i = 1'b1;
        ifu_adr_i = 32'h800;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("t6_gnt", ifu_gnt_o, 1'b1);
        step();
        ifu_req_i = 1'b0;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk1("t6_busy", busy_o, 1'b1);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD4BAD4;
        reset_n      = 1'b0;
        #1;
        chk_quiet("t6_reset");
        $display("reset asserted in wait");
        step();
        mem_rvalid_i = 1'b0;
        reset_n      = 1'b1;
        lsu_req_i    = 1'b1;
        lsu_adr_i    = 32'h900;
        mem_gnt_i    = 1'b1;
        @(negedge clk);
        chk1("t6_lsu_gnt", lsu_gnt_o, 1'b1);
        chk("t6_adr", mem_adr_o, 32'h900);
        sb.push_back('{1'b1, 32'h00000012});
        step();
        lsu_req_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00000012;
        step();
        mem_rvalid_i = 1'b0;
        step();

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IFU) and the execute-stage load/store unit (LSU).
- Arbitrates requests, holds the winning request stable until the memory grants it, and allows exactly one outstanding transaction.
- Routes the read response back to the owning requester, drops fetch responses cancelled by a pipeline flush, and generates byte enables and lane-aligned store data.

Parameters:
- XLEN, 32, data/address width
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IFU waits before IFU is forced to win (>=1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ifu_req_i  in  1  fetch request; held with ifu_adr_i until ifu_gnt_o
- ifu_adr_i  in  XLEN  fetch address, word aligned
- ifu_flush_i  in  1  pipeline flush; cancels the response of an in-flight fetch
- ifu_gnt_o  out  1  fetch request accepted by memory this cycle
- ifu_rvalid_o  out  1  fetch data valid, one-cycle pulse
- ifu_rdata_o  out  XLEN  fetch data
- lsu_req_i  in  1  load/store request; held with its attributes until lsu_gnt_o
- lsu_adr_i  in  XLEN  byte address
- lsu_we_i  in  1  1 = store
- lsu_size_i  in  3  access size; [1:0]: 00 byte, 01 half, 10 word; bit 2 ignored
- lsu_wdata_i  in  XLEN  store data, right-justified
- lsu_gnt_o  out  1  LSU request accepted by memory this cycle
- lsu_rvalid_o  out  1  load data valid or store done, one-cycle pulse
- lsu_rdata_o  out  XLEN  raw memory word (extension is done by the LSU)
- mem_req_o  out  1  memory request
- mem_adr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  XLEN  lane-aligned store data
- mem_gnt_i  in  1  memory accepts the request in the cycle mem_req_o=1
- mem_rvalid_i  in  1  response of the outstanding transaction, >=1 cycle after the grant
- mem_rdata_i  in  XLEN  response data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, owner_q=IFU, streak_q=0, drop_q=0. All outputs are 0 while in IDLE with no request. Asserting reset mid-transaction abandons the transaction; the memory is reset alongside.
- Arbitration, IDLE only:
  - LSU wins if lsu_req_i=1, unless streak_q==MAX_LSU_STREAK and ifu_req_i=1, in which case IFU wins.
  - The request is driven combinationally the same cycle: mem_req_o=1, with the muxed address and attributes.
- States:
  - IDLE: if a request wins and mem_gnt_i=1, go to WAIT. If a request wins and mem_gnt_i=0, latch owner_q and go to ISSUE. With no request, stay in IDLE.
  - ISSUE: mem_req_o=1 from owner_q's inputs; a new LSU request cannot preempt. On mem_gnt_i go to WAIT.
  - WAIT: mem_req_o=0. On mem_rvalid_i, pulse the owner's rvalid for that cycle and go to IDLE; the next request issues in the following cycle earliest.
- Grant: {ifu,lsu}_gnt_o = mem_req_o & mem_gnt_i & (selected owner == that requester).
- Streak counter:
  - On an LSU grant with ifu_req_i=1: streak_q saturates-increments to MAX_LSU_STREAK.
  - On an LSU grant with ifu_req_i=0: streak_q holds.
  - On any IFU grant: streak_q clears to 0.
- IFU-owned requests: mem_we_o=0, mem_be_o=4'b1111.
- LSU-owned requests:
  - mem_be_o = byte 0001, half 0011, word 1111, each shifted left by adr[1:0].
  - mem_wdata_o = lsu_wdata_i shifted left by 8*adr[1:0], truncated to XLEN.
  - Misalignment is not checked here (execute traps before requesting).
- mem_adr_o = the owner's full address, unmodified.
- Flush:
  - drop_q sets if ifu_flush_i=1 while the IFU owns a transaction in ISSUE or WAIT, or while the IFU is granted in IDLE that cycle.
  - While drop_q or ifu_flush_i is set, ifu_rvalid_o is forced to 0. A flush in the same cycle as mem_rvalid_i also suppresses the response.
  - drop_q clears on return to IDLE.
  - Flush never withdraws a request already on the memory port.
- Data: ifu_rdata_o and lsu_rdata_o = mem_rdata_i, qualified only by their rvalid.
- Simultaneous ifu_req_i and lsu_req_i in IDLE with streak_q < MAX: the LSU wins and the IFU keeps requesting.
- mem_rvalid_i outside WAIT is a protocol error; it is ignored and raises no pulse.

Test Plan:
- IFU alone, adr=0x100, gnt same cycle, rvalid 2 cycles later, rdata=0xDEADBEEF -> ifu_gnt_o at t0, ifu_rvalid_o pulse at t2 with 0xDEADBEEF, busy_o high t1..t2.
- Both request in IDLE, mem_gnt_i low 3 cycles -> LSU owns; mem_adr_o stays at the LSU address through ISSUE; lsu_gnt_o on cycle 4; IFU served next.
- LSU store of a half at adr=0x203, wdata=0x0000ABCD -> mem_be_o=4'b1000 (truncated), mem_wdata_o=0xCD000000, mem_we_o=1. Half at 0x202 -> be=1100, wdata=0xABCD0000.
- Continuous LSU requests with IFU waiting, MAX_LSU_STREAK=4 -> 4 LSU grants, then 1 IFU grant, streak_q back to 0.
- IFU granted, flush in WAIT, then rvalid -> no ifu_rvalid_o; the next IFU fetch returns normally. Flush coincident with rvalid -> suppressed.
- reset_n pulsed low in WAIT -> all outputs 0 and state IDLE immediately; a new request is granted normally after release.
